// File: rtl/datamem_arbiter_pkg.sv
// Shared types and constants for the two-master data memory burst arbiter.
package datamem_arbiter_pkg;

   typedef enum logic {
      ARB_IDLE = 1'b0,
      ARB_BUSY = 1'b1
   } arb_state_t;

   localparam int   WORD_BYTES = 4;
   localparam logic M_CPU      = 1'b0;
   localparam logic M_DMA      = 1'b1;

endpackage

// File: rtl/datamem_arbiter_if.sv
// Master-side burst request/response signals plus the single-port memory bus.
interface datamem_arbiter_if #(
   parameter int WORD_SIZE = 32,
   parameter int LEN_W     = 4
);
   logic                 m0_req;
   logic                 m0_we;
   logic [WORD_SIZE-1:0] m0_addr;
   logic [LEN_W-1:0]     m0_len;
   logic [WORD_SIZE-1:0] m0_wd;
   logic                 m0_gnt;
   logic                 m0_rvalid;
   logic [WORD_SIZE-1:0] m0_rdata;

   logic                 m1_req;
   logic                 m1_we;
   logic [WORD_SIZE-1:0] m1_addr;
   logic [LEN_W-1:0]     m1_len;
   logic [WORD_SIZE-1:0] m1_wd;
   logic                 m1_gnt;
   logic                 m1_rvalid;
   logic [WORD_SIZE-1:0] m1_rdata;

   logic                 mem_we;
   logic [WORD_SIZE-1:0] mem_addr;
   logic [WORD_SIZE-1:0] mem_wd;
   logic [WORD_SIZE-1:0] mem_rd;

   modport slave (
      input  m0_req, m0_we, m0_addr, m0_len, m0_wd,
      input  m1_req, m1_we, m1_addr, m1_len, m1_wd,
      input  mem_rd,
      output m0_gnt, m0_rvalid, m0_rdata,
      output m1_gnt, m1_rvalid, m1_rdata,
      output mem_we, mem_addr, mem_wd
   );

   modport master (
      output m0_req, m0_we, m0_addr, m0_len, m0_wd,
      output m1_req, m1_we, m1_addr, m1_len, m1_wd,
      output mem_rd,
      input  m0_gnt, m0_rvalid, m0_rdata,
      input  m1_gnt, m1_rvalid, m1_rdata,
      input  mem_we, mem_addr, mem_wd
   );

endinterface

// File: rtl/datamem_arbiter_rr_pick2.sv
// Combinational 2-way burst picker; round-robin by default, fixed m0 priority
// when DATAMEM_ARB_PRIO_EN is defined.
module rr_pick2
   import datamem_arbiter_pkg::*;
(
   input  logic req0,
   input  logic req1,
   input  logic last,
   output logic valid,
   output logic winner
);

   always_comb begin
      valid  = req0 | req1;
      winner = M_CPU;
`ifdef DATAMEM_ARB_PRIO_EN
      if (!req0 && req1)
         winner = M_DMA;
`else
      // on contention the master that did not own the previous burst wins
      if (req0 && req1)
         winner = ~last;
      else if (req1)
         winner = M_DMA;
`endif
   end

endmodule

// File: rtl/datamem_arbiter.sv
// Two-master burst arbiter in front of the single-port data memory.
// Arbitration policy selected by DATAMEM_ARB_PRIO_EN (see rr_pick2).
//
// state    | meaning
// ARB_IDLE | no grant, sample requests, latch winner's burst
// ARB_BUSY | one beat per cycle for owner until cnt reaches zero
module datamem_arbiter
   import datamem_arbiter_pkg::*;
#(
   parameter int WORD_SIZE = 32,
   parameter int LEN_W     = 4
)(
   input  logic             clk,
   input  logic             rst,
   datamem_arbiter_if.slave bus
);

   arb_state_t           state;
   logic                 owner;
   logic                 owner_we;
   logic                 last;
   logic [LEN_W-1:0]     cnt;
   logic [WORD_SIZE-1:0] cur_addr;
   logic                 pick_valid;
   logic                 pick_winner;
   logic                 busy;
   logic                 rd_beat0;
   logic                 rd_beat1;

   rr_pick2 u_pick (
      .req0   (bus.m0_req),
      .req1   (bus.m1_req),
      .last   (last),
      .valid  (pick_valid),
      .winner (pick_winner)
   );

   assign busy     = (state == ARB_BUSY);
   assign rd_beat0 = busy & ~owner_we & (owner == M_CPU);
   assign rd_beat1 = busy & ~owner_we & (owner == M_DMA);

   assign bus.m0_gnt   = busy & (owner == M_CPU);
   assign bus.m1_gnt   = busy & (owner == M_DMA);
   assign bus.mem_we   = busy & owner_we;
   assign bus.mem_addr = busy ? cur_addr : '0;
   assign bus.mem_wd   = !busy ? '0 : ((owner == M_DMA) ? bus.m1_wd : bus.m0_wd);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state         <= ARB_IDLE;
         owner         <= M_CPU;
         owner_we      <= 1'b0;
         last          <= M_DMA;
         cnt           <= '0;
         cur_addr      <= '0;
         bus.m0_rvalid <= 1'b0;
         bus.m1_rvalid <= 1'b0;
         bus.m0_rdata  <= '0;
         bus.m1_rdata  <= '0;
      end else begin
         bus.m0_rvalid <= rd_beat0;
         bus.m1_rvalid <= rd_beat1;
         if (rd_beat0)
            bus.m0_rdata <= bus.mem_rd;
         if (rd_beat1)
            bus.m1_rdata <= bus.mem_rd;

         case (state)
            ARB_IDLE: begin
               if (pick_valid) begin
                  owner    <= pick_winner;
                  owner_we <= (pick_winner == M_DMA) ? bus.m1_we  : bus.m0_we;
                  cnt      <= (pick_winner == M_DMA) ? bus.m1_len : bus.m0_len;
                  // byte offset within the word is dropped at capture
                  cur_addr <= ((pick_winner == M_DMA) ? bus.m1_addr : bus.m0_addr)
                              & ~WORD_SIZE'(WORD_BYTES - 1);
                  state    <= ARB_BUSY;
               end
            end
            ARB_BUSY: begin
               if (cnt == '0) begin
                  state <= ARB_IDLE;
                  last  <= owner;
               end else begin
                  cnt      <= cnt - LEN_W'(1);
                  cur_addr <= cur_addr + WORD_SIZE'(WORD_BYTES);
               end
            end
            default: state <= ARB_IDLE;
         endcase
      end
   end

endmodule

// File: doc/datamem_arbiter.md
Name: datamem_arbiter

Overview:
- Two-master burst arbiter in front of the single-port data memory.
- Memory timing: combinational read, write on clk.
- Master 0 is the CPU load/store port; master 1 is the DMA/debug port.
- Round-robin grant per burst; generates word-incrementing addresses and one memory access per cycle.

Parameters:
WORD_SIZE, 32, data/address width
LEN_W, 4, burst length field width (max burst 2^LEN_W words)

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
m0_req  in  1  master 0 burst request
m0_we  in  1  master 0 burst is write
m0_addr  in  WORD_SIZE  master 0 byte base address (word aligned)
m0_len  in  LEN_W  master 0 beats minus one
m0_wd  in  WORD_SIZE  master 0 write data for current beat
m0_gnt  out  1  master 0 beat accepted this cycle
m0_rvalid  out  1  master 0 read data valid
m0_rdata  out  WORD_SIZE  master 0 read data
m1_*  same set as m0_* for master 1
mem_we  out  1  memory write enable
mem_addr  out  WORD_SIZE  memory byte address
mem_wd  out  WORD_SIZE  memory write data
mem_rd  in  WORD_SIZE  memory read data (combinational on mem_addr)

Behaviour:
- Clock is clk. Reset is rst: asynchronous, active-high.
- Reset values:
  - state=IDLE, owner=0, last=1 (so m0 wins first contention), cnt=0, cur_addr=0.
  - All gnt, rvalid and mem_we are 0. All rdata are 0.
- States: IDLE, BUSY.
- IDLE:
  - No gnt is asserted and mem_we=0.
  - If exactly one req is high, that master wins.
  - If both are high, the master != last wins.
  - On a win, register owner, we, cnt=len and cur_addr=addr, then go to BUSY next cycle.
  - Latency: first gnt is one cycle after req is sampled.
- BUSY:
  - gnt of owner=1 every cycle (combinational from state/owner); the other gnt=0.
  - mem_addr=cur_addr, mem_we=owner_we.
  - mem_wd=owner's m*_wd, muxed combinationally; the master must drive the beat's data whenever its gnt is high.
  - If cnt==0: go to IDLE and set last=owner.
  - Otherwise: cnt decrements and cur_addr advances by 4.
  - Burst of len+1 beats takes len+1 consecutive cycles. One mandatory IDLE cycle separates bursts, including back-to-back bursts from the same master.
- Reads:
  - On each read beat, mem_rd is registered into the owner's rdata.
  - Owner's rvalid=1 on the following cycle (1-cycle read latency).
  - rdata holds its value when rvalid=0.
  - The non-owner rvalid stays 0.
- Writes: rvalid is never asserted.
- In IDLE, mem_addr=0 and mem_wd=0.
- Boundaries:
  - cur_addr increments modulo 2^WORD_SIZE (wraps 0xFFFFFFFC -> 0x0).
  - addr[1:0] is ignored (forced to 0 on mem_addr).
  - len=0 gives a single beat. len=all-ones gives 2^LEN_W beats.
  - Dropping req mid-burst is ignored; the burst always completes.
  - A new request from the non-owner during BUSY is held off and is considered in the next IDLE.
  - Async reset mid-burst: immediately IDLE and all outputs go to reset values; the in-flight burst is discarded and no rvalid follows.

Optional Feature:
- Macro: DATAMEM_ARB_PRIO_EN.
- Defined: fixed priority. m0 always wins simultaneous requests and `last` is unused. Everything else is unchanged.
- Undefined: round-robin as specified above.

Decomposition:
- Shared package:
  - state enum (ARB_IDLE, ARB_BUSY)
  - constant WORD_BYTES=4
  - master-index constants M_CPU=0, M_DMA=1
- Sub-module rr_pick2:
  - Combinational 2-way picker.
  - Inputs: req0, req1, last. Outputs: valid, winner.
  - Holds both the round-robin and the priority variant selected by the macro.
- Remainder stays in datamem_arbiter.

Test Plan:
- Single read burst: m0 req, addr=0x40, len=3, we=0, memory preloaded.
  - m0_gnt high for 4 cycles starting 1 cycle after req.
  - mem_addr = 0x40, 0x44, 0x48, 0x4C.
  - m0_rvalid 4 cycles, lagging gnt by 1, with matching data.
- Write burst: m1 req, we=1, addr=0x100, len=1, wd=0xA5A5A5A5 then 0x5A5A5A5A.
  - mem_we on 2 cycles; a later read returns both words in order.
  - m1_rvalid never asserts.
- Contention: both req in the same cycle with len=0, held asserted.
  - Grants alternate m0, m1, m0, m1, with one IDLE cycle between each.
  - With DATAMEM_ARB_PRIO_EN: always m0.
- Wrap: m0 read, addr=0xFFFFFFF8, len=2 -> mem_addr = 0xFFFFFFF8, 0xFFFFFFFC, 0x00000000.
- Reset mid-burst: assert rst during beat 2 of a len=7 read.
  - Same edge: all gnt, rvalid and mem_we go to 0 and state is IDLE.
  - After release: m0 wins first contention.
- Late requester: m1 raises req during m0's len=3 burst.
  - m1_gnt stays 0 until m0 completes, then m1 is granted after one IDLE cycle.
